// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: FSM state codes,
// RV32 base opcodes and the opcode classification bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef struct packed {
    logic legal;
    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_beq;
  } op_class_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier; anything outside the five supported
// opcodes comes back with legal=0 and no class bit set.
module op_decode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:     cls.is_r     = 1'b1;
      OP_I:     cls.is_i     = 1'b1;
      OP_LOAD:  cls.is_load  = 1'b1;
      OP_STORE: cls.is_store = 1'b1;
      OP_BEQ:   cls.is_beq   = 1'b1;
      default:  cls          = '0;
    endcase
    cls.legal = cls.is_r | cls.is_i | cls.is_load | cls.is_store | cls.is_beq;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXECUTE/MEM/WB/HALT with
// combinational datapath controls and a retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  output logic       imem_req,
  input  logic       imem_ready,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       dmem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       PCSrc,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       halted,
  output logic [2:0] state,
  output logic [7:0] instr_count
);

  state_t     state_q;
  state_t     state_n;
  logic [6:0] op_q;
  logic [7:0] count_q;
  op_class_t  cls;
  logic [6:0] dec_in;

  logic imem_req_c, ir_write_c, pc_write_c, pcsrc_c;
  logic reg_write_c, mem_read_c, mem_write_c, alu_src_c, halted_c;

  // The live opcode is only looked at in DECODE; later states use op_q.
  assign dec_in = (state_q == S_DECODE) ? opcode : op_q;

  op_decode u_op_decode (
    .opcode (dec_in),
    .cls    (cls)
  );

  always_comb begin
    state_n     = state_q;
    imem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pcsrc_c     = 1'b0;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    alu_src_c   = 1'b0;
    halted_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_n    = S_DECODE;
        end
      end
      S_DECODE: state_n = cls.legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: begin
        alu_src_c = cls.is_i | cls.is_load | cls.is_store;
        if (cls.is_beq) begin
          pc_write_c = 1'b1;
          pcsrc_c    = zero;
          state_n    = S_FETCH;
        end else if (cls.is_r | cls.is_i) begin
          state_n = S_WB;
        end else if (cls.is_load | cls.is_store) begin
          state_n = S_MEM;
        end else begin
          state_n = S_HALT;
        end
      end
      S_MEM: begin
        mem_read_c  = cls.is_load;
        mem_write_c = cls.is_store;
        if (!(cls.is_load | cls.is_store)) begin
          state_n = S_HALT;
        end else if (dmem_ready) begin
          if (cls.is_store) begin
            pc_write_c = 1'b1;
            state_n    = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_n     = S_FETCH;
      end
      default: begin
        // HALT and the unused codes 6-7 all park here until reset.
        halted_c = 1'b1;
        state_n  = S_HALT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == S_DECODE) op_q <= opcode;
      if (pc_write_c) count_q <= count_q + 8'd1;
    end
  end

  // Reset masks every control immediately, aborting any memory access in flight.
  assign imem_req    = ~reset & imem_req_c;
  assign ir_write    = ~reset & ir_write_c;
  assign pc_write    = ~reset & pc_write_c;
  assign PCSrc       = ~reset & pcsrc_c;
  assign reg_write   = ~reset & reg_write_c;
  assign mem_read    = ~reset & mem_read_c;
  assign mem_write   = ~reset & mem_write_c;
  assign alu_src     = ~reset & alu_src_c;
  assign halted      = ~reset & halted_c;
  assign state       = state_q;
  assign instr_count = reset ? 8'd0 : count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change on the falling edge,
// outputs are checked 1 ns later against hand-computed values.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       imem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_write, pc_write, PCSrc, reg_write;
  logic       mem_read, mem_write, alu_src, halted;
  logic [2:0] state;
  logic [7:0] instr_count;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // Control vector {imem_req, ir_write, pc_write, PCSrc, reg_write,
  //                 mem_read, mem_write, alu_src, halted}
  localparam logic [8:0] C_IREQ = 9'h100;
  localparam logic [8:0] C_IRW  = 9'h080;
  localparam logic [8:0] C_PCW  = 9'h040;
  localparam logic [8:0] C_PCS  = 9'h020;
  localparam logic [8:0] C_RW   = 9'h010;
  localparam logic [8:0] C_MR   = 9'h008;
  localparam logic [8:0] C_MW   = 9'h004;
  localparam logic [8:0] C_ALU  = 9'h002;
  localparam logic [8:0] C_HLT  = 9'h001;
  localparam logic [8:0] C_NONE = 9'h000;

  logic [8:0] ctl;
  assign ctl = {imem_req, ir_write, pc_write, PCSrc, reg_write,
                mem_read, mem_write, alu_src, halted};

  multicycle_ctrl dut (
    .CLK         (CLK),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .opcode      (opcode),
    .zero        (zero),
    .dmem_ready  (dmem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .PCSrc       (PCSrc),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .halted      (halted),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic rst, input logic irdy, input logic [6:0] op,
                       input logic z, input logic drdy);
    @(negedge CLK);
    reset      = rst;
    imem_ready = irdy;
    opcode     = op;
    zero       = z;
    dmem_ready = drdy;
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, then check state, control vector and count.
  task automatic cyc(input string tag, input logic rst, input logic irdy,
                     input logic [6:0] op, input logic z, input logic drdy,
                     input logic [2:0] exp_st, input logic [8:0] exp_ctl,
                     input logic [7:0] exp_cnt);
    drive(rst, irdy, op, z, drdy);
    check({tag, ".state"}, {6'd0, state}, {6'd0, exp_st});
    check({tag, ".ctl"}, ctl, exp_ctl);
    check({tag, ".count"}, {1'b0, instr_count}, {1'b0, exp_cnt});
  endtask

  initial begin
    // Reset hold: FETCH, every output quiet even with imem_ready high.
    cyc("rst0", 1, 1, R, 0, 1, 3'd0, C_NONE, 8'd0);
    cyc("rst1", 1, 1, R, 0, 1, 3'd0, C_NONE, 8'd0);

    // R-type with both memories ready.
    cyc("r_fetch", 0, 1, R, 0, 1, 3'd0, C_IREQ | C_IRW, 8'd0);
    cyc("r_dec",   0, 1, R, 0, 1, 3'd1, C_NONE, 8'd0);
    cyc("r_exe",   0, 1, R, 0, 1, 3'd2, C_NONE, 8'd0);
    cyc("r_wb",    0, 1, R, 0, 1, 3'd4, C_RW | C_PCW, 8'd0);

    // BEQ taken.
    cyc("bt_fetch", 0, 1, BQ, 1, 1, 3'd0, C_IREQ | C_IRW, 8'd1);
    cyc("bt_dec",   0, 1, BQ, 1, 1, 3'd1, C_NONE, 8'd1);
    cyc("bt_exe",   0, 1, BQ, 1, 1, 3'd2, C_PCW | C_PCS, 8'd1);

    // BEQ not taken.
    cyc("bn_fetch", 0, 1, BQ, 0, 1, 3'd0, C_IREQ | C_IRW, 8'd2);
    cyc("bn_dec",   0, 1, BQ, 0, 1, 3'd1, C_NONE, 8'd2);
    cyc("bn_exe",   0, 1, BQ, 0, 1, 3'd2, C_PCW, 8'd2);

    // LOAD with a three-cycle data-memory stall.
    cyc("ld_fetch", 0, 1, LD, 0, 0, 3'd0, C_IREQ | C_IRW, 8'd3);
    cyc("ld_dec",   0, 1, LD, 0, 0, 3'd1, C_NONE, 8'd3);
    cyc("ld_exe",   0, 1, LD, 0, 0, 3'd2, C_ALU, 8'd3);
    cyc("ld_mem0",  0, 1, LD, 0, 0, 3'd3, C_MR, 8'd3);
    cyc("ld_mem1",  0, 1, LD, 0, 0, 3'd3, C_MR, 8'd3);
    cyc("ld_mem2",  0, 1, LD, 0, 0, 3'd3, C_MR, 8'd3);
    cyc("ld_mem3",  0, 1, LD, 0, 1, 3'd3, C_MR, 8'd3);
    cyc("ld_wb",    0, 1, LD, 0, 0, 3'd4, C_RW | C_PCW, 8'd3);

    // STORE with the same stall; retires in the last MEM cycle.
    cyc("st_fetch", 0, 1, ST, 0, 0, 3'd0, C_IREQ | C_IRW, 8'd4);
    cyc("st_dec",   0, 1, ST, 0, 0, 3'd1, C_NONE, 8'd4);
    cyc("st_exe",   0, 1, ST, 0, 0, 3'd2, C_ALU, 8'd4);
    cyc("st_mem0",  0, 1, ST, 0, 0, 3'd3, C_MW, 8'd4);
    cyc("st_mem1",  0, 1, ST, 0, 0, 3'd3, C_MW, 8'd4);
    cyc("st_mem2",  0, 1, ST, 0, 0, 3'd3, C_MW, 8'd4);
    cyc("st_mem3",  0, 1, ST, 0, 1, 3'd3, C_MW | C_PCW, 8'd4);

    // I-type; opcode bus is garbage after DECODE and must be ignored.
    cyc("i_fetch", 0, 1, I,   0, 1, 3'd0, C_IREQ | C_IRW, 8'd5);
    cyc("i_dec",   0, 1, I,   0, 1, 3'd1, C_NONE, 8'd5);
    cyc("i_exe",   0, 1, BAD, 0, 1, 3'd2, C_ALU, 8'd5);
    cyc("i_wb",    0, 1, BAD, 0, 1, 3'd4, C_RW | C_PCW, 8'd5);

    // Instruction-memory stall: five waiting cycles then one ir_write.
    for (int k = 0; k < 5; k++)
      cyc("if_stall", 0, 0, R, 0, 1, 3'd0, C_IREQ, 8'd6);
    cyc("if_go",  0, 1, R, 0, 1, 3'd0, C_IREQ | C_IRW, 8'd6);
    cyc("if_dec", 0, 0, R, 0, 1, 3'd1, C_NONE, 8'd6);
    cyc("if_exe", 0, 0, R, 0, 1, 3'd2, C_NONE, 8'd6);
    cyc("if_wb",  0, 0, R, 0, 1, 3'd4, C_RW | C_PCW, 8'd6);

    // Illegal opcode halts until reset.
    cyc("ill_fetch", 0, 1, BAD, 0, 1, 3'd0, C_IREQ | C_IRW, 8'd7);
    cyc("ill_dec",   0, 1, BAD, 0, 1, 3'd1, C_NONE, 8'd7);
    for (int k = 0; k < 3; k++)
      cyc("ill_halt", 0, 1, R, 1, 1, 3'd5, C_HLT, 8'd7);
    cyc("ill_rst",   1, 0, R, 0, 0, 3'd5, C_NONE, 8'd0);
    cyc("ill_after", 0, 0, R, 0, 0, 3'd0, C_IREQ, 8'd0);

    // 256 back-to-back BEQ retirements wrap the counter.
    for (int n = 0; n < 255; n++) begin
      drive(0, 1, BQ, 1, 0);
      drive(0, 1, BQ, 1, 0);
      drive(0, 1, BQ, 1, 0);
    end
    cyc("wrap_255", 0, 1, BQ, 0, 0, 3'd0, C_IREQ | C_IRW, 8'd255);
    cyc("wrap_dec", 0, 1, BQ, 0, 0, 3'd1, C_NONE, 8'd255);
    cyc("wrap_exe", 0, 1, BQ, 0, 0, 3'd2, C_PCW, 8'd255);

    // Reset in the middle of a STORE access aborts it the same cycle.
    cyc("sr_fetch", 0, 1, ST, 0, 0, 3'd0, C_IREQ | C_IRW, 8'd0);
    cyc("sr_dec",   0, 1, ST, 0, 0, 3'd1, C_NONE, 8'd0);
    cyc("sr_exe",   0, 1, ST, 0, 0, 3'd2, C_ALU, 8'd0);
    cyc("sr_mem",   0, 1, ST, 0, 0, 3'd3, C_MW, 8'd0);
    cyc("sr_rst",   1, 1, ST, 0, 1, 3'd3, C_NONE, 8'd0);
    cyc("sr_after", 0, 0, ST, 0, 1, 3'd0, C_IREQ, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising-edge active.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: imem_req  out  1  instruction fetch request.
REQ-004 SHALL have: imem_ready  in  1  instruction memory has the word.
REQ-005 SHALL have: opcode  in  7  instruction bits [6:0].
REQ-006 SHALL have: zero  in  1  ALU zero flag.
REQ-007 SHALL have: dmem_ready  in  1  data memory done.
REQ-008 SHALL have: ir_write, pc_write, PCSrc, reg_write, mem_read, mem_write, alu_src  out  1 each  datapath controls; PCSrc drives the pc block select.
REQ-009 SHALL have: halted  out  1;  state  out  3;  instr_count  out  8  retired-instruction count.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5; codes 6-7 unreachable, treated as HALT.
REQ-011 FETCH: imem_req=1; on imem_ready=1 pulse ir_write=1 that cycle and go to DECODE; else stay.
REQ-012 DECODE: register opcode into op_q; illegal opcode -> HALT; legal -> EXECUTE.
REQ-013 Legal opcodes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BEQ=1100011.
REQ-014 EXECUTE: alu_src=1 for I/LOAD/STORE, else 0; BEQ -> pc_write=1, PCSrc=zero, go FETCH; R/I -> WB; LOAD/STORE -> MEM.
REQ-015 MEM: mem_read=1 (LOAD) or mem_write=1 (STORE) held until dmem_ready=1; on ready STORE -> pc_write=1, PCSrc=0, go FETCH; LOAD -> WB.
REQ-016 WB: reg_write=1, pc_write=1, PCSrc=0 for one cycle, go FETCH.
REQ-017 HALT: halted=1, all other controls 0; leaves only via reset.
REQ-018 All controls SHALL be combinational from state, op_q, zero, imem_ready, dmem_ready; no control asserted outside the states listed above.
REQ-019 instr_count SHALL increment on every cycle with pc_write=1; wraps 255 -> 0.
REQ-020 opcode SHALL be sampled only in DECODE; imem_ready ignored outside FETCH; dmem_ready ignored outside MEM.
REQ-021 pc_write SHALL be asserted exactly once per retired instruction; never in FETCH, DECODE or HALT.

Reset
REQ-022 reset=1 at a rising edge SHALL set state=FETCH, op_q=0, instr_count=0.
REQ-023 While reset=1 all outputs except state SHALL be forced 0 combinationally, including mid-MEM (aborts access same cycle).
REQ-024 First cycle after reset release SHALL be FETCH with imem_req=1.

Structure
REQ-025 State enum and opcode constants SHALL live in shared package cpu_pkg.
REQ-026 Opcode classification (legal, is_r, is_i, is_load, is_store, is_beq) SHALL be one combinational sub-module op_decode.
REQ-027 Sequential state SHALL be limited to state register, op_q, instr_count.

Verification
REQ-028 R-type 0110011, imem_ready and dmem_ready tied 1 -> states 0,1,2,4; reg_write and pc_write high in cycle 4, PCSrc=0, instr_count 0->1.
REQ-029 BEQ 1100011 with zero=1 -> pc_write=1, PCSrc=1 in EXECUTE (cycle 3); zero=0 -> PCSrc=0; reg_write never asserted.
REQ-030 LOAD 0000011, dmem_ready low 3 cycles then high -> mem_read high 4 cycles, then WB with reg_write=1; total 8 cycles; STORE same stall -> pc_write in final MEM cycle, no WB.
REQ-031 imem_ready low 5 cycles in FETCH -> imem_req held, ir_write=0 until ready, then single ir_write pulse.
REQ-032 Illegal opcode 1111111 -> HALT, halted=1 indefinitely; reset=1 one cycle -> state=0, instr_count=0, halted=0.
REQ-033 256 back-to-back BEQ retirements -> instr_count wraps to 0; reset asserted during MEM of a STORE -> mem_write=0 same cycle, no pc_write.
